// File: rtl/exe_md_stage.sv
// Execute stage: stage register, operand forwarding, ALU, branch/jump target and an
// iterative RV32M multiply/divide unit that holds the pipeline while it runs.
//   state  | meaning
//   S_IDLE | no M-op in flight; captures operand magnitudes when an M-op is registered
//   S_RUN  | one shift-add or restoring-subtract step per cycle, count_q down to 0
//   S_DONE | result presented; waits here while stall is high
module exe_md_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int FSW     = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_rs1_data,
  input  logic [XLEN-1:0]         in_rs2_data,
  input  logic [XLEN-1:0]         in_imm,
  input  logic [4:0]              in_op,
  input  logic                    in_is_branch,
  input  logic                    in_is_jump,
  input  logic                    in_alu_op1_sel,
  input  logic                    in_alu_op2_sel,
  input  logic                    in_jb_op1_sel,
  input  logic [FSW-1:0]          rs1_fwd_sel,
  input  logic [FSW-1:0]          rs2_fwd_sel,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic                    busy,
  output logic                    out_valid,
  output logic [XLEN-1:0]         out_result,
  output logic [XLEN-1:0]         out_rs2_data,
  output logic                    jb_taken,
  output logic [XLEN-1:0]         jb_target
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_t;

  md_state_t state_q, state_d;

  logic            valid_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [4:0]      op_q;
  logic            is_branch_q, is_jump_q, alu_op1_sel_q, alu_op2_sel_q, jb_op1_sel_q;
  logic            load;

  logic [XLEN-1:0] rs1_f, rs2_f, op1, op2, alu_res, jb_sum;
  logic [SHW-1:0]  shamt;
  logic            cond;

  logic [SHW-1:0]  count_q;
  logic [XLEN-1:0] acc_q, lo_q, opa_q, acc_d, lo_d;
  logic            neg_q, dz_q;
  logic            a_neg, b_neg, md_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_shift;
  logic [XLEN-1:0] div_sub;
  logic            div_ge;
  logic [2*XLEN-1:0] mul_prod, mul_sgn;
  logic [XLEN-1:0] quot, rem, m_res;

  assign load = !stall && !busy;

  always_ff @(posedge clk) begin
    if (rst || flush) valid_q <= 1'b0;
    else if (load)    valid_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      pc_q          <= in_pc;
      rs1_q         <= in_rs1_data;
      rs2_q         <= in_rs2_data;
      imm_q         <= in_imm;
      op_q          <= in_op;
      is_branch_q   <= in_is_branch;
      is_jump_q     <= in_is_jump;
      alu_op1_sel_q <= in_alu_op1_sel;
      alu_op2_sel_q <= in_alu_op2_sel;
      jb_op1_sel_q  <= in_jb_op1_sel;
    end
  end

  // Selects above NUM_FWD match no source and fall back to the register value.
  always_comb begin
    rs1_f = rs1_q;
    rs2_f = rs2_q;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (rs1_fwd_sel == FSW'(k + 1)) rs1_f = fwd_data[k*XLEN +: XLEN];
      if (rs2_fwd_sel == FSW'(k + 1)) rs2_f = fwd_data[k*XLEN +: XLEN];
    end
  end

  always_comb begin
    op1   = alu_op1_sel_q ? pc_q : rs1_f;
    op2   = alu_op2_sel_q ? imm_q : rs2_f;
    shamt = op2[SHW-1:0];
    case (op_q[2:0])
      3'b000:  alu_res = op_q[3] ? op1 - op2 : op1 + op2;
      3'b001:  alu_res = op1 << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      3'b100:  alu_res = op1 ^ op2;
      3'b101:  alu_res = op_q[3] ? $unsigned($signed(op1) >>> shamt) : op1 >> shamt;
      3'b110:  alu_res = op1 | op2;
      default: alu_res = op1 & op2;
    endcase
  end

  always_comb begin
    case (op_q[2:0])
      3'b000:  cond = rs1_f == rs2_f;
      3'b001:  cond = rs1_f != rs2_f;
      3'b100:  cond = $signed(rs1_f) <  $signed(rs2_f);
      3'b101:  cond = $signed(rs1_f) >= $signed(rs2_f);
      3'b110:  cond = rs1_f <  rs2_f;
      3'b111:  cond = rs1_f >= rs2_f;
      default: cond = 1'b0;
    endcase
    jb_sum = (jb_op1_sel_q ? pc_q : rs1_f) + imm_q;
  end

  assign jb_target    = {jb_sum[XLEN-1:1], 1'b0};
  assign jb_taken     = valid_q && (is_jump_q || (is_branch_q && cond));
  assign out_rs2_data = rs2_f;

  // Operand signedness per funct3: rs1 signed for MUL/MULH/MULHSU/DIV/REM, rs2 for MUL/MULH/DIV/REM.
  always_comb begin
    a_neg  = (op_q[2:0] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110}) && rs1_f[XLEN-1];
    b_neg  = (op_q[2:0] inside {3'b000, 3'b001, 3'b100, 3'b110}) && rs2_f[XLEN-1];
    a_mag  = a_neg ? -rs1_f : rs1_f;
    b_mag  = b_neg ? -rs2_f : rs2_f;
    md_neg = (op_q[2:0] == 3'b110) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opa_q};
    div_sub   = div_shift[XLEN-1:0] - opa_q;
    if (op_q[2]) begin
      acc_d = div_ge ? div_sub : div_shift[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      acc_d = mul_sum[XLEN:1];
      lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      count_q <= SHW'(XLEN - 1);
      acc_q   <= '0;
      lo_q    <= op_q[2] ? a_mag : b_mag;
      opa_q   <= op_q[2] ? b_mag : a_mag;
      neg_q   <= md_neg;
      dz_q    <= (rs2_f == '0);
    end else if (state_q == S_RUN) begin
      count_q <= count_q - 1'b1;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_q && op_q[4]) state_d = S_RUN;
      S_RUN:   if (count_q == '0)      state_d = S_DONE;
      S_DONE:  if (!stall)             state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // MIN / -1 falls out of the magnitude path; only the divide-by-zero quotient needs overriding.
  always_comb begin
    mul_prod = {acc_q, lo_q};
    mul_sgn  = neg_q ? -mul_prod : mul_prod;
    quot     = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
    rem      = neg_q ? -acc_q : acc_q;
    if (op_q[2])               m_res = op_q[1] ? rem : quot;
    else if (op_q[1:0] == 2'b00) m_res = mul_sgn[XLEN-1:0];
    else                       m_res = mul_sgn[2*XLEN-1:XLEN];
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_IDLE && valid_q && op_q[4]);
  assign out_valid = valid_q && (!op_q[4] || state_q == S_DONE);

  always_comb begin
    if (op_q[4])        out_result = m_res;
    else if (is_jump_q) out_result = pc_q + XLEN'(4);
    else                out_result = alu_res;
  end

endmodule

// File: tb/tb_exe_md_stage.sv
// Directed bench for exe_md_stage: ALU, forwarding, stall/flush, M-unit latency and
// special cases, branch/jump redirect.
module tb_exe_md_stage;
  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int FSW     = $clog2(NUM_FWD + 1);

  logic clk = 1'b0;
  logic rst, stall, flush, in_valid;
  logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0] in_op;
  logic in_is_branch, in_is_jump, in_alu_op1_sel, in_alu_op2_sel, in_jb_op1_sel;
  logic [FSW-1:0] rs1_fwd_sel, rs2_fwd_sel;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic busy, out_valid, jb_taken;
  logic [XLEN-1:0] out_result, out_rs2_data, jb_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_md_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .FSW(FSW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_op(in_op), .in_is_branch(in_is_branch), .in_is_jump(in_is_jump),
    .in_alu_op1_sel(in_alu_op1_sel), .in_alu_op2_sel(in_alu_op2_sel),
    .in_jb_op1_sel(in_jb_op1_sel), .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
    .fwd_data(fwd_data), .busy(busy), .out_valid(out_valid), .out_result(out_result),
    .out_rs2_data(out_rs2_data), .jb_taken(jb_taken), .jb_target(jb_target)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc, input logic br,
                       input logic jmp, input logic a1, input logic a2, input logic j1);
    in_valid = 1'b1; in_op = op; in_rs1_data = a; in_rs2_data = b; in_imm = imm; in_pc = pc;
    in_is_branch = br; in_is_jump = jmp; in_alu_op1_sel = a1; in_alu_op2_sel = a2;
    in_jb_op1_sel = j1;
  endtask

  task automatic run_alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic a2,
                         input logic [31:0] exp);
    drive(op, a, b, imm, 32'h40, 1'b0, 1'b0, 1'b0, a2, 1'b0);
    tick;
    chk({tag, " valid"}, {31'b0, out_valid}, 32'd1);
    chk(tag, out_result, exp);
  endtask

  task automatic run_m(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold);
    int n;
    drive(op, a, b, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick;
    end
    chk({tag, " busy cycles"}, n, XLEN + 1);
    chk({tag, " valid"}, {31'b0, out_valid}, 32'd1);
    chk(tag, out_result, exp);
    repeat (hold) begin
      stall = 1'b1;
      tick;
      chk({tag, " held valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, " held result"}, out_result, exp);
    end
    stall = 1'b0;
    tick;
    chk({tag, " retired"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(5'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rs1_fwd_sel = '0; rs2_fwd_sel = '0; fwd_data = '0;
    tick; tick;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset jb_taken", {31'b0, jb_taken}, 32'd0);
    rst = 1'b0;

    fwd_data = {32'hAAAA0000, 32'h00000010};
    rs1_fwd_sel = 2'd1;
    run_alu("add fwd", 5'b00000, 32'h999, 32'h0, 32'h5, 1'b1, 32'h15);
    rs1_fwd_sel = 2'd0;
    run_alu("sub", 5'b01000, 32'd10, 32'd3, 32'h0, 1'b0, 32'd7);
    run_alu("sra", 5'b01101, 32'h80000000, 32'd4, 32'h0, 1'b0, 32'hF8000000);
    run_alu("srl", 5'b00101, 32'h80000000, 32'd4, 32'h0, 1'b0, 32'h08000000);
    run_alu("sll shamt wrap", 5'b00001, 32'd1, 32'h0, 32'h25, 1'b1, 32'h20);
    run_alu("slt", 5'b00010, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 32'd1);
    run_alu("sltu", 5'b00011, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 32'd0);
    run_alu("xor", 5'b00100, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 32'h0FF0);
    run_alu("or", 5'b00110, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 32'hFFF0);
    run_alu("and", 5'b00111, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 32'hF000);
    rs2_fwd_sel = 2'd2;
    run_alu("fwd src1", 5'b00000, 32'd1, 32'd2, 32'h0, 1'b0, 32'hAAAA0001);
    chk("store data fwd", out_rs2_data, 32'hAAAA0000);
    rs2_fwd_sel = 2'd3;
    run_alu("fwd sel out of range", 5'b00000, 32'd1, 32'd2, 32'h0, 1'b0, 32'd3);
    rs2_fwd_sel = 2'd0;

    run_alu("stall first", 5'b00000, 32'd1, 32'd2, 32'h0, 1'b0, 32'd3);
    stall = 1'b1;
    drive(5'b00000, 32'd10, 32'd20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    chk("stall hold result", out_result, 32'd3);
    stall = 1'b0;
    tick;
    chk("stall release result", out_result, 32'd30);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush alu valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0;
    tick;

    run_m("mul", 5'b10000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 0);
    run_m("mulhu", 5'b10011, 32'hFFFFFFFF, 32'd2, 32'h00000001, 0);
    run_m("mulh", 5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    run_m("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_m("div ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run_m("rem ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
    run_m("divu by 0", 5'b10101, 32'd7, 32'd0, 32'hFFFFFFFF, 0);
    run_m("remu by 0", 5'b10111, 32'd7, 32'd0, 32'd7, 0);
    run_m("div neg by 0", 5'b10100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 0);
    run_m("rem neg by 0", 5'b10110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 0);
    run_m("div -7/2 stall", 5'b10100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 3);
    run_m("rem -7/2", 5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0);

    drive(5'b10101, 32'd100, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    in_valid = 1'b0;
    repeat (10) tick;
    chk("divu running busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    run_alu("add after flush", 5'b00000, 32'd40, 32'd2, 32'h0, 1'b0, 32'd42);

    drive(5'b00100, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    chk("blt taken", {31'b0, jb_taken}, 32'd1);
    chk("blt target", jb_target, 32'h120);
    drive(5'b00101, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    chk("bge not taken", {31'b0, jb_taken}, 32'd0);
    drive(5'b00110, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    chk("bltu not taken", {31'b0, jb_taken}, 32'd0);
    drive(5'b00000, 32'd5, 32'd5, 32'h8, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    chk("beq taken", {31'b0, jb_taken}, 32'd1);
    chk("beq target", jb_target, 32'h108);
    drive(5'b00000, 32'h203, 32'h0, 32'h0, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    chk("jalr taken", {31'b0, jb_taken}, 32'd1);
    chk("jalr target", jb_target, 32'h202);
    chk("jalr link", out_result, 32'h304);
    in_valid = 1'b0;
    tick;
    chk("idle not taken", {31'b0, jb_taken}, 32'd0);

    drive(5'b10000, 32'd3, 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst mid-mul busy", {31'b0, busy}, 32'd0);
    chk("rst mid-mul valid", {31'b0, out_valid}, 32'd0);
    tick;
    chk("rst mid-mul stays idle", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exe_md_stage.md
Name: exe_md_stage

Overview:
- Parametrised execute stage: pipeline register, N-source operand forwarding, single-cycle ALU and branch/jump target unit.
- Adds an iterative multiply/divide unit (RV32M semantics) that holds the pipeline while it runs.
- Sits between decode/issue and MEM.
- Register-file read happens upstream; this stage receives already-read operands.

Parameters:
- XLEN, 32, datapath width; must be even and >= 8.
- NUM_FWD, 2, number of forwarding sources; index 0 has highest priority (youngest).
- FSW, $clog2(NUM_FWD+1), width of a forwarding select.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream hold; stage register keeps its contents
- flush  in  1  kill the instruction in, or entering, EXE
- in_valid  in  1  instruction offered by decode
- in_pc  in  XLEN  instruction PC
- in_rs1_data  in  XLEN  register-file rs1 value
- in_rs2_data  in  XLEN  register-file rs2 value
- in_imm  in  XLEN  sign-extended immediate
- in_op  in  5  [4]=M-ext, [3]=alt (SUB/SRA), [2:0]=funct3
- in_is_branch  in  1  conditional branch
- in_is_jump  in  1  JAL/JALR
- in_alu_op1_sel  in  1  0=rs1, 1=pc
- in_alu_op2_sel  in  1  0=rs2, 1=imm
- in_jb_op1_sel  in  1  0=rs1, 1=pc
- rs1_fwd_sel  in  FSW  0=register value, k=fwd_data source k-1; applies to the registered instruction
- rs2_fwd_sel  in  FSW  same, for rs2
- fwd_data  in  NUM_FWD*XLEN  forwarding values; source k occupies bits [k*XLEN +: XLEN]
- busy  out  1  M-op in progress; upstream must hold
- out_valid  out  1  result valid to MEM this cycle
- out_result  out  XLEN  ALU or M-unit result
- out_rs2_data  out  XLEN  forwarded rs2 (store data)
- jb_taken  out  1  redirect request
- jb_target  out  XLEN  redirect address, bit 0 forced to 0

Behaviour:
- Stage register:
  - Loads all in_* fields when !stall && !busy.
  - flush clears valid_q on the same edge, overriding any load.
  - rst clears valid_q and sets FSM to IDLE.
  - Data fields are don't-care after reset.
- Forwarding:
  - Select value > NUM_FWD behaves as 0.
  - Operands are combinational from valid_q fields and fwd_data.
- ALU (combinational):
  - ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND per funct3 and alt.
  - Shift amount is op2[$clog2(XLEN)-1:0].
- Branch/jump:
  - jb_target = (jb_op1_sel ? pc : rs1) + imm, with bit 0 cleared.
  - jb_taken = valid_q && (is_jump || (is_branch && cond)).
  - cond is BEQ/BNE/BLT/BGE/BLTU/BGEU on forwarded rs1/rs2 per funct3.
  - For jumps, out_result = pc + 4.
- M-unit FSM states IDLE, RUN, DONE:
  - IDLE: when valid_q && op[4], busy=1 combinationally. Next state RUN, count=XLEN-1. Operands are captured as magnitudes and result sign is recorded.
  - RUN: one shift-add (MUL*) or restoring-subtract (DIV*/REM*) iteration per cycle; busy=1. Goes to DONE after the count==0 iteration.
  - DONE: busy=0, out_valid=1, out_result holds the sign-corrected result. Stays in DONE while stall=1. Goes to IDLE when the stage register advances.
  - Total EXE occupancy of an M-op is XLEN+2 cycles with stall low.
  - The FSM ignores downstream stall during RUN; stall only matters in DONE.
- MUL results: low XLEN bits; MULH/MULHSU/MULHU give the high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned products respectively.
- Divide by zero: quotient = all ones, remainder = dividend (signed and unsigned).
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- Special cases still take the full fixed latency.
- flush or rst in RUN/DONE: FSM to IDLE, busy=0, out_valid=0 next cycle, no result produced.
- Non-M ops: out_valid = valid_q, zero added latency.
- Reset values: busy=0, out_valid=0, jb_taken=0. out_result, out_rs2_data and jb_target are don't-care while out_valid=0.

Test Plan:
- ADD with rs1_fwd_sel=1, fwd_data[0]=0x10, in_imm=0x5, op2_sel=1 -> out_valid next cycle, out_result=0x15.
- MUL 0xFFFFFFFF×0x2 and MULHU of the same, XLEN=32 -> busy high 33 cycles, then MUL=0xFFFFFFFE and MULHU=0x1, each on out_valid in cycle 34.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
- DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; stall held 3 cycles in DONE -> result stable, out_valid stays 1.
- flush at RUN cycle 10 of a DIVU -> busy=0, out_valid=0 next cycle; following ADD completes normally.
- BLT rs1=-1, rs2=0, pc=0x100, imm=0x20, jb_op1_sel=1 -> jb_taken=1, jb_target=0x120; JALR rs1=0x203, imm=0 -> target 0x202, out_result=pc+4.
